fsm_pipeline_responder: RTL and testbench

Consumes the 2-bit pipeline control code from the entropy overlay FSM (00 Normal, 01 Stall, 10 Flush, 11 Lock) and converts it into per-stage stall/flush strobes for the CPU pipeline. Flushes are sequenced over a fixed number of cycles, and lock exit requires a debounced release. Completion and timeout status flows back toward the overlay and debug logic. Sits between the overlay FSM output and the IF/ID/EX/MEM pipeline registers.

---
 rtl/fsm_pipeline_responder.sv | 208 ++++++++++++++++++++
 tb/tb_fsm_pipeline_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_pipeline_responder.sv
// fsm_pipeline_responder
//   Turns the 2-bit overlay control code (00 Normal, 01 Stall, 10 Flush,
//   11 Lock) into per-stage stall/flush strobes for the IF/ID/EX/MEM
//   pipeline. Flushes run for a fixed number of cycles, and LOCK is left
//   only after a debounced run of Normal codes. All outputs are registered
//   (Moore); an input change shows up one cycle after it is sampled.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   fsm_state_in   control code from the overlay FSM
//   stall_pc       hold the program counter
//   stall_if_id    hold the IF/ID register
//   flush_if_id    bubble IF/ID
//   flush_id_ex    bubble ID/EX
//   flush_ex_mem   bubble EX/MEM
//   lock_halt      pipeline frozen, commits blocked
//   flush_done     one-cycle pulse in the first HOLD cycle after a flush
//   stall_timeout  one-cycle pulse once per stall, after STALL_TIMEOUT cycles
//   resp_state     000 RUN, 001 STALL, 010 FLUSH, 011 HOLD, 100 LOCK
//   stall_cycles   length of current/last stall, saturating at 255
//   flush_count    completed flushes, wrapping at 256
module fsm_pipeline_responder #(
    parameter int FLUSH_CYCLES  = 3,
    parameter int STALL_TIMEOUT = 64,
    parameter int UNLOCK_QUAL   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] fsm_state_in,
    output logic       stall_pc,
    output logic       stall_if_id,
    output logic       flush_if_id,
    output logic       flush_id_ex,
    output logic       flush_ex_mem,
    output logic       lock_halt,
    output logic       flush_done,
    output logic       stall_timeout,
    output logic [2:0] resp_state,
    output logic [7:0] stall_cycles,
    output logic [7:0] flush_count
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'b000,
        ST_STALL = 3'b001,
        ST_FLUSH = 3'b010,
        ST_HOLD  = 3'b011,
        ST_LOCK  = 3'b100
    } state_e;

    typedef enum logic [1:0] {
        CODE_NORMAL = 2'b00,
        CODE_STALL  = 2'b01,
        CODE_FLUSH  = 2'b10,
        CODE_LOCK   = 2'b11
    } code_e;

    localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] QUAL_LAST   = 4'(UNLOCK_QUAL - 1);
    localparam logic [7:0] TIMEOUT_VAL = 8'(STALL_TIMEOUT);

    code_e      code;
    state_e     state_q, state_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;
    logic [3:0] qual_cnt_q, qual_cnt_d;
    logic [7:0] stall_cycles_q, stall_cycles_d;
    logic [7:0] flush_count_q, flush_count_d;
    logic       flush_done_q, flush_done_d;
    logic       stall_timeout_q, stall_timeout_d;
    logic       timeout_fired_q, timeout_fired_d;

    assign code = code_e'(fsm_state_in);

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            flush_cnt_q     <= '0;
            qual_cnt_q      <= '0;
            stall_cycles_q  <= '0;
            flush_count_q   <= '0;
            flush_done_q    <= 1'b0;
            stall_timeout_q <= 1'b0;
            timeout_fired_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            qual_cnt_q      <= qual_cnt_d;
            stall_cycles_q  <= stall_cycles_d;
            flush_count_q   <= flush_count_d;
            flush_done_q    <= flush_done_d;
            stall_timeout_q <= stall_timeout_d;
            timeout_fired_q <= timeout_fired_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        qual_cnt_d      = qual_cnt_q;
        stall_cycles_d  = stall_cycles_q;
        flush_count_d   = flush_count_q;
        flush_done_d    = 1'b0;
        stall_timeout_d = 1'b0;
        timeout_fired_d = timeout_fired_q;

        // Stall accounting runs for every STALL cycle, independent of the
        // code, so the timeout pulse survives an exit in the same cycle.
        if (state_q == ST_STALL) begin
            if (stall_cycles_q != 8'hFF) begin
                stall_cycles_d = stall_cycles_q + 8'd1;
            end
            if (stall_cycles_q == TIMEOUT_VAL && !timeout_fired_q) begin
                stall_timeout_d = 1'b1;
                timeout_fired_d = 1'b1;
            end
        end

        if (code == CODE_LOCK) begin
            state_d    = ST_LOCK;
            qual_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RUN, ST_HOLD: begin
                    if (code == CODE_NORMAL) begin
                        state_d = ST_RUN;
                    end else if (code == CODE_STALL) begin
                        state_d         = ST_STALL;
                        stall_cycles_d  = '0;
                        timeout_fired_d = 1'b0;
                    end else if (state_q == ST_RUN) begin
                        // Sustained Flush in HOLD does not re-arm
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end
                ST_STALL: begin
                    if (code == CODE_NORMAL) begin
                        state_d = ST_RUN;
                    end else if (code == CODE_FLUSH) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_d       = ST_HOLD;
                        flush_done_d  = 1'b1;
                        flush_count_d = flush_count_q + 8'd1;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 4'd1;
                    end
                end
                ST_LOCK: begin
                    if (code == CODE_NORMAL) begin
                        if (qual_cnt_q == QUAL_LAST) begin
                            state_d    = ST_RUN;
                            qual_cnt_d = '0;
                        end else begin
                            qual_cnt_d = qual_cnt_q + 4'd1;
                        end
                    end else begin
                        qual_cnt_d = '0;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Output decode from registered state
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        lock_halt    = 1'b0;
        case (state_q)
            ST_STALL: begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
            end
            ST_FLUSH: begin
                stall_pc     = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end
            ST_HOLD: stall_pc = 1'b1;
            ST_LOCK: begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                lock_halt   = 1'b1;
            end
            default: ;
        endcase
    end

    assign flush_done    = flush_done_q;
    assign stall_timeout = stall_timeout_q;
    assign resp_state    = state_q;
    assign stall_cycles  = stall_cycles_q;
    assign flush_count   = flush_count_q;

endmodule

// File: tb/tb_fsm_pipeline_responder.sv
module tb_fsm_pipeline_responder;

    localparam int FC = 3;
    localparam int ST = 64;
    localparam int UQ = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] fsm_state_in;
    logic       stall_pc, stall_if_id, flush_if_id, flush_id_ex, flush_ex_mem;
    logic       lock_halt, flush_done, stall_timeout;
    logic [2:0] resp_state;
    logic [7:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    fsm_pipeline_responder #(
        .FLUSH_CYCLES (FC),
        .STALL_TIMEOUT(ST),
        .UNLOCK_QUAL  (UQ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fsm_state_in (fsm_state_in),
        .stall_pc     (stall_pc),
        .stall_if_id  (stall_if_id),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_ex_mem (flush_ex_mem),
        .lock_halt    (lock_halt),
        .flush_done   (flush_done),
        .stall_timeout(stall_timeout),
        .resp_state   (resp_state),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural reference model ----------------
    // mode: 0 run, 1 stall, 2 flush, 3 hold, 4 lock (the resp_state codes)
    int m_mode = 0;
    int m_age = 0;       // FLUSH cycles spent so far, including current
    int m_zeros = 0;     // consecutive Normal codes seen in LOCK
    int m_len = 0;       // stall length
    int m_flushes = 0;   // completed flushes
    bit m_done = 0, m_to = 0, m_fired = 0;

    task automatic model_step(input bit r, input logic [1:0] c);
        if (r) begin
            m_mode = 0; m_age = 0; m_zeros = 0; m_len = 0; m_flushes = 0;
            m_done = 0; m_to = 0; m_fired = 0;
            return;
        end
        m_done = 0;
        m_to = 0;
        if (m_mode == 1) begin
            if (m_len == ST && !m_fired) begin
                m_to = 1;
                m_fired = 1;
            end
            if (m_len < 255) m_len = m_len + 1;
        end
        if (c == 2'd3) begin
            m_mode = 4;
            m_zeros = 0;
        end else begin
            case (m_mode)
                0, 3: begin
                    if (c == 2'd0) m_mode = 0;
                    else if (c == 2'd1) begin m_mode = 1; m_len = 0; m_fired = 0; end
                    else if (m_mode == 0) begin m_mode = 2; m_age = 1; end
                end
                1: begin
                    if (c == 2'd0) m_mode = 0;
                    else if (c == 2'd2) begin m_mode = 2; m_age = 1; end
                end
                2: begin
                    if (m_age >= FC) begin
                        m_mode = 3;
                        m_done = 1;
                        m_flushes = (m_flushes + 1) % 256;
                    end else m_age = m_age + 1;
                end
                default: begin
                    if (c == 2'd0) begin
                        m_zeros = m_zeros + 1;
                        if (m_zeros >= UQ) begin m_mode = 0; m_zeros = 0; end
                    end else m_zeros = 0;
                end
            endcase
        end
    endtask

    function automatic logic [26:0] model_vec();
        return {3'(m_mode), m_mode != 0, (m_mode == 1 || m_mode == 4),
                m_mode == 2, m_mode == 2, m_mode == 2, m_mode == 4,
                m_done, m_to, 8'(m_len), 8'(m_flushes)};
    endfunction

    function automatic logic [26:0] dut_vec();
        return {resp_state, stall_pc, stall_if_id, flush_if_id, flush_id_ex,
                flush_ex_mem, lock_halt, flush_done, stall_timeout,
                stall_cycles, flush_count};
    endfunction

    // Expected strobes for a given resp_state, straight from the state table
    function automatic logic [5:0] strobes_for(input logic [2:0] s);
        case (s)
            3'd1:    return 6'b110000;
            3'd2:    return 6'b101110;
            3'd3:    return 6'b100000;
            3'd4:    return 6'b110001;
            default: return 6'b000000;
        endcase
    endfunction

    // One clock: drive at negedge, sample 1 time unit after the posedge
    task automatic cyc(input bit r, input logic [1:0] c);
        @(negedge clk);
        rst = r;
        fsm_state_in = c;
        @(posedge clk);
        model_step(r, c);
        #1;
    endtask

    typedef struct {
        bit         r;
        logic [1:0] c;
        logic [2:0] st;
        bit         done;
        logic [7:0] cnt;
    } vec_t;

    vec_t tv[$];

    task automatic add(input bit r, input logic [1:0] c, input logic [2:0] st,
                       input bit done, input logic [7:0] cnt);
        vec_t v;
        v.r = r; v.c = c; v.st = st; v.done = done; v.cnt = cnt;
        tv.push_back(v);
    endtask

    initial begin
        int unsigned pulses;
        int unsigned pulse_at;
        logic [1:0]  rc;
        int unsigned hold;

        rst = 1'b1;
        fsm_state_in = 2'd0;

        // Reset with Lock applied, debounce, flush, abort, mid-flush reset
        add(1, 3, 0, 0, 0); add(1, 3, 0, 0, 0);
        add(0, 3, 4, 0, 0);
        add(0, 0, 4, 0, 0); add(0, 0, 4, 0, 0); add(0, 0, 4, 0, 0);
        add(0, 1, 4, 0, 0);
        add(0, 0, 4, 0, 0); add(0, 0, 4, 0, 0); add(0, 0, 4, 0, 0);
        add(0, 0, 0, 0, 0);
        add(0, 2, 2, 0, 0); add(0, 2, 2, 0, 0); add(0, 2, 2, 0, 0);
        add(0, 2, 3, 1, 1); add(0, 2, 3, 0, 1); add(0, 2, 3, 0, 1);
        add(0, 0, 0, 0, 1);
        add(0, 2, 2, 0, 1); add(0, 2, 2, 0, 1); add(0, 2, 2, 0, 1);
        add(0, 2, 3, 1, 2);
        add(0, 0, 0, 0, 2);
        add(0, 2, 2, 0, 2); add(0, 2, 2, 0, 2);
        add(0, 3, 4, 0, 2);
        add(1, 0, 0, 0, 0);
        add(0, 2, 2, 0, 0); add(0, 2, 2, 0, 0);
        add(1, 2, 0, 0, 0);
        add(0, 0, 0, 0, 0);
        add(0, 2, 2, 0, 0); add(0, 2, 2, 0, 0); add(0, 2, 2, 0, 0);
        add(0, 3, 4, 0, 0);
        add(0, 3, 4, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            cyc(tv[i].r, tv[i].c);
            check($sformatf("tbl%0d_outs", i),
                  {resp_state, stall_pc, stall_if_id, flush_if_id, flush_id_ex,
                   flush_ex_mem, lock_halt, flush_done, stall_timeout},
                  {tv[i].st, strobes_for(tv[i].st), tv[i].done, 1'b0});
            check($sformatf("tbl%0d_flush_count", i), flush_count, tv[i].cnt);
        end

        // Long stall: one timeout pulse, saturation, hold after exit
        cyc(1, 0);
        pulses = 0;
        pulse_at = 0;
        for (int i = 1; i <= 300; i++) begin
            cyc(0, 1);
            if (stall_timeout) begin
                pulses++;
                pulse_at = i;
            end
        end
        check("stall_pulse_count", pulses, 1);
        check("stall_pulse_cycle", pulse_at, 66);
        check("stall_saturated", stall_cycles, 255);
        cyc(0, 0);
        check("stall_exit_state", resp_state, 0);
        check("stall_hold_1", stall_cycles, 255);
        cyc(0, 0);
        check("stall_hold_2", stall_cycles, 255);

        // Timeout coinciding with exit from STALL
        cyc(0, 1);
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(0, 1);
            if (stall_timeout) pulses++;
        end
        check("early_pulses", pulses, 0);
        check("at_timeout_len", stall_cycles, 64);
        cyc(0, 0);
        check("exit_pulse", stall_timeout, 1);
        check("exit_state", resp_state, 0);
        check("exit_len", stall_cycles, 65);
        cyc(0, 0);
        check("pulse_single", stall_timeout, 0);
        check("model_sync", dut_vec(), model_vec());

        // Randomized runs against the reference model
        for (int n = 0; n < 600; n++) begin
            rc = 2'($urandom_range(0, 3));
            hold = ($urandom_range(0, 15) == 0) ? $urandom_range(60, 80)
                                                 : $urandom_range(1, 8);
            for (int k = 0; k < hold; k++) begin
                cyc($urandom_range(0, 199) == 0, rc);
                check("random", dut_vec(), model_vec());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
